sha_digest_axis_serializer: RTL and testbench

- Successor digest-output stage for the SHA3 core. Captures a finished 1600-bit Keccak state, truncates it to the SHA3 digest length selected by TID (or passes the full state), and streams it out as an AXI4-Stream master.
- Adds over the previous generation: true TVALID/TREADY backpressure, TKEEP for partial last beats, parametrised beat width, a load handshake, zero-bubble back-to-back digests, and async reset.

---
 rtl/sha_digest_axis_serializer.sv | 159 +++++++++++++++
 tb/tb_sha_digest_axis_serializer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_digest_axis_serializer.sv
// SHA3 digest output stage: captures a finished 1600-bit Keccak state,
// truncates it to the digest length selected by TID (or keeps the whole
// state), and streams it out as an AXI4-Stream master with TKEEP on the
// final partial beat and zero-bubble back-to-back packets.
module sha_digest_axis_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter bit BYTE_SWAP  = 1'b1
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [1599:0]           state_i,
    input  logic                    state_valid,
    output logic                    state_ready,
    input  logic [1:0]              tid_i,
    input  logic                    mode_i,
    output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXIS_TKEEP,
    output logic                    M_AXIS_TVALID,
    input  logic                    M_AXIS_TREADY,
    output logic                    M_AXIS_TLAST,
    output logic [1:0]              M_AXIS_TID
);

    localparam int BPB = DATA_WIDTH / 8;   // bytes per beat

    if (!(DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
        $error("sha_digest_axis_serializer: DATA_WIDTH must be 16, 32 or 64");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } fsm_t;

    fsm_t            r_fsm;
    fsm_t            w_fsm_next;

    // Capture register doubles as a shift register: the current beat is
    // always in its low DATA_WIDTH bits, so no wide output mux is needed.
    logic [1599:0]   r_shift;
    logic [1:0]      r_tid;
    logic            r_mode;
    logic [6:0]      r_beat;
    logic            r_live;       // 0 during reset, 1 from first edge after

    logic [7:0]      w_bytes;
    logic [6:0]      w_last_idx;
    int              w_rem;
    logic            w_is_last;
    logic            w_hs;
    logic            w_load;
    logic [BPB-1:0]  w_keep;
    logic [DATA_WIDTH-1:0] w_masked;
    logic [DATA_WIDTH-1:0] w_swapped;

    // Packet length in bytes for the captured mode/tid.
    function automatic logic [7:0] pkt_bytes(input logic mode, input logic [1:0] tid);
        if (!mode) return 8'd200;
        case (tid)
            2'd0:    return 8'd28;
            2'd1:    return 8'd32;
            2'd2:    return 8'd48;
            default: return 8'd64;
        endcase
    endfunction

    // Index of the final beat: ceil(bytes / BPB) - 1.
    function automatic logic [6:0] last_beat(input logic [7:0] nbytes);
        int b;
        b = (int'(nbytes) + BPB - 1) / BPB - 1;
        return 7'(b);
    endfunction

    // Packet geometry and handshake terms derived from the captured request.
    always_comb begin
        w_bytes    = pkt_bytes(r_mode, r_tid);
        w_last_idx = last_beat(w_bytes);
        w_rem      = int'(w_bytes) % BPB;
        if (w_rem == 0) w_rem = BPB;
        w_is_last  = (r_beat == w_last_idx);
        w_hs       = M_AXIS_TVALID && M_AXIS_TREADY;
        state_ready = r_live && ((r_fsm == S_IDLE) ||
                                 ((r_fsm == S_SEND) && w_is_last && M_AXIS_TREADY));
        w_load     = state_valid && state_ready;
    end

    // FSM state register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_fsm <= S_IDLE;
        else          r_fsm <= w_fsm_next;
    end

    // Next-state logic and beat-valid output.
    // NOTE: every output of a combinational block gets a default first so a
    // missed branch cannot infer a latch.
    always_comb begin
        w_fsm_next    = r_fsm;
        M_AXIS_TVALID = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                if (w_load) w_fsm_next = S_SEND;
            end
            S_SEND: begin
                M_AXIS_TVALID = 1'b1;
                if (w_hs && w_is_last && !w_load) w_fsm_next = S_IDLE;
            end
            default: w_fsm_next = S_IDLE;
        endcase
    end

    // Reset-release tracker: holds state_ready low until the first clock
    // edge after ARESETn deasserts.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_live <= 1'b0;
        else          r_live <= 1'b1;
    end

    // Capture on load, shift one beat out on each non-final handshake.
    // NOTE: the 1600-bit capture register is reset because its contents
    // feed TDATA directly; a plain storage array would not need this.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_shift <= '0;
            r_tid   <= '0;
            r_mode  <= 1'b0;
            r_beat  <= '0;
        end else if (w_load) begin
            r_shift <= state_i;
            r_tid   <= tid_i;
            r_mode  <= mode_i;
            r_beat  <= '0;
        end else if (w_hs && !w_is_last) begin
            r_shift <= r_shift >> DATA_WIDTH;
            r_beat  <= r_beat + 7'd1;
        end
    end

    // Beat formatting: TKEEP, zeroing of invalid bytes, optional half-word swap.
    always_comb begin
        w_keep    = '0;
        w_masked  = '0;
        w_swapped = '0;
        for (int j = 0; j < BPB; j++) begin
            w_keep[j]        = !w_is_last || (j < w_rem);
            w_masked[8*j +: 8] = r_shift[8*j +: 8] & {8{w_keep[j]}};
        end
        for (int j = 0; j < BPB; j++) begin
            if (BYTE_SWAP) w_swapped[8*j +: 8] = w_masked[8*(j ^ 1) +: 8];
            else           w_swapped[8*j +: 8] = w_masked[8*j +: 8];
        end
        M_AXIS_TDATA = M_AXIS_TVALID ? w_swapped : '0;
        M_AXIS_TKEEP = M_AXIS_TVALID ? w_keep    : '0;
        M_AXIS_TLAST = M_AXIS_TVALID && w_is_last;
        M_AXIS_TID   = r_tid;
    end

endmodule

// File: tb/tb_sha_digest_axis_serializer.sv
// Bench for sha_digest_axis_serializer: a W=16/BYTE_SWAP=1 instance and a
// W=64/BYTE_SWAP=0 instance, a byte-stream model of the expected beats, a
// per-cycle compare process, and directed tests with literal expectations.
module tb_sha_digest_axis_serializer;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [1599:0] st16, st64;
    logic          sv16, sv64, sr16, sr64;
    logic [1:0]    tid16, tid64;
    logic          mode16, mode64;
    logic [15:0]   td16;
    logic [1:0]    tk16;
    logic          tv16, trdy16, tl16;
    logic [1:0]    oid16;
    logic [63:0]   td64;
    logic [7:0]    tk64;
    logic          tv64, trdy64, tl64;
    logic [1:0]    oid64;

    sha_digest_axis_serializer #(.DATA_WIDTH(16), .BYTE_SWAP(1'b1)) dut16 (
        .ACLK(clk), .ARESETn(rst_n), .state_i(st16), .state_valid(sv16),
        .state_ready(sr16), .tid_i(tid16), .mode_i(mode16),
        .M_AXIS_TDATA(td16), .M_AXIS_TKEEP(tk16), .M_AXIS_TVALID(tv16),
        .M_AXIS_TREADY(trdy16), .M_AXIS_TLAST(tl16), .M_AXIS_TID(oid16));

    sha_digest_axis_serializer #(.DATA_WIDTH(64), .BYTE_SWAP(1'b0)) dut64 (
        .ACLK(clk), .ARESETn(rst_n), .state_i(st64), .state_valid(sv64),
        .state_ready(sr64), .tid_i(tid64), .mode_i(mode64),
        .M_AXIS_TDATA(td64), .M_AXIS_TKEEP(tk64), .M_AXIS_TVALID(tv64),
        .M_AXIS_TREADY(trdy64), .M_AXIS_TLAST(tl64), .M_AXIS_TID(oid64));

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [1:0]  tid;
        int          cyc;
    } beat_t;

    beat_t q16[$], q64[$], cap16[$], cap64[$], ref16[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    logic  stall16 = 1'b0, stall64 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no event, expected one within budget", name);
    endtask

    // Reference byte stream: byte n of the packet is state bits [8n+7:8n];
    // bytes are packed low-first into beats, then optionally pair-swapped.
    task automatic model_push(input int w, input bit swap, input logic [1599:0] st,
                              input logic mode, input logic [1:0] tid);
        int nbytes, bpb, nbeats;
        beat_t b;
        logic [63:0] raw;
        if (!mode) nbytes = 200;
        else begin
            case (tid)
                2'd0: nbytes = 28;
                2'd1: nbytes = 32;
                2'd2: nbytes = 48;
                default: nbytes = 64;
            endcase
        end
        bpb    = w / 8;
        nbeats = (nbytes + bpb - 1) / bpb;
        for (int i = 0; i < nbeats; i++) begin
            raw    = '0;
            b.keep = '0;
            for (int j = 0; j < bpb; j++) begin
                if (i * bpb + j < nbytes) begin
                    raw[8*j +: 8] = st[8*(i*bpb+j) +: 8];
                    b.keep[j] = 1'b1;
                end
            end
            b.data = raw;
            if (swap)
                for (int j = 0; j < bpb; j++) b.data[8*j +: 8] = raw[8*(j^1) +: 8];
            b.last = (i == nbeats - 1);
            b.tid  = tid;
            b.cyc  = 0;
            if (w == 16) q16.push_back(b);
            else         q64.push_back(b);
        end
    endtask

    task automatic cmp_inst(input int w, input logic tv, input logic [63:0] td,
                            input logic [7:0] tk, input logic tl, input logic [1:0] oid,
                            input logic trdy, input logic was_stall, output logic now_stall);
        string tag;
        beat_t e, o;
        tag = (w == 16) ? "w16" : "w64";
        if (was_stall && !tv) check({tag, " tvalid held during stall"}, {63'b0, tv}, 64'd1);
        now_stall = tv && !trdy;
        if (tv) begin
            if ((w == 16 && q16.size() == 0) || (w == 64 && q64.size() == 0)) begin
                check({tag, " unexpected beat tvalid"}, {63'b0, tv}, 64'd0);
            end else begin
                e = (w == 16) ? q16[0] : q64[0];
                check({tag, " tdata"}, td, e.data);
                check({tag, " tkeep"}, {56'b0, tk}, {56'b0, e.keep});
                check({tag, " tlast"}, {63'b0, tl}, {63'b0, e.last});
                check({tag, " tid"},   {62'b0, oid}, {62'b0, e.tid});
                if (trdy) begin
                    o.data = td; o.keep = tk; o.last = tl; o.tid = oid; o.cyc = cyc;
                    if (w == 16) begin void'(q16.pop_front()); cap16.push_back(o); end
                    else         begin void'(q64.pop_front()); cap64.push_back(o); end
                end
            end
        end
    endtask

    // Compare process: checks both instances against the model every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall16 = 1'b0;
            stall64 = 1'b0;
        end else begin
            cmp_inst(16, tv16, {48'b0, td16}, {6'b0, tk16}, tl16, oid16, trdy16, stall16, stall16);
            cmp_inst(64, tv64, td64, tk64, tl64, oid64, trdy64, stall64, stall64);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a load and wait for its handshake; returns at posedge+1.
    task automatic load(input int w, input logic [1599:0] st, input logic mode,
                        input logic [1:0] tid, input bit keep_valid);
        bit done;
        done = 1'b0;
        if (w == 16) begin st16 = st; mode16 = mode; tid16 = tid; sv16 = 1'b1; end
        else         begin st64 = st; mode64 = mode; tid64 = tid; sv64 = 1'b1; end
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if ((w == 16 && sr16) || (w == 64 && sr64)) begin
                model_push(w, w == 16, st, mode, tid);
                done = 1'b1;
            end
            step();
        end
        if (!done) fail_now("load handshake timeout");
        if (!keep_valid) begin
            if (w == 16) sv16 = 1'b0;
            else         sv64 = 1'b0;
        end
    endtask

    task automatic wait_idle(input int w);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            #1;
            if (w == 16 && q16.size() == 0 && !tv16) done = 1'b1;
            if (w == 64 && q64.size() == 0 && !tv64) done = 1'b1;
        end
        if (!done) fail_now("packet drain timeout");
        step();
    endtask

    function automatic logic [1599:0] make_pat();
        logic [1599:0] s;
        for (int k = 0; k < 25; k++) s[64*k +: 64] = {8{8'(k)}};
        s[63:0] = 64'h0706050403020100;
        return s;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1599:0] pat;
        bit hit;
        pat = make_pat();
        sv16 = 0; sv64 = 0; st16 = '0; st64 = '0; tid16 = 0; tid64 = 0;
        mode16 = 0; mode64 = 0; trdy16 = 1; trdy64 = 1;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("reset w16 state_ready", {63'b0, sr16}, 64'd0);
        check("reset w16 tvalid", {63'b0, tv16}, 64'd0);
        check("reset w16 tdata", {48'b0, td16}, 64'd0);
        check("reset w16 tkeep/tlast/tid", {59'b0, tk16, tl16, oid16}, 64'd0);
        check("reset w64 tvalid/tlast", {62'b0, tv64, tl64}, 64'd0);
        check("reset w64 tdata", td64, 64'd0);
        check("reset w64 tkeep/tid", {54'b0, tk64, oid64}, 64'd0);
        #10;
        check("reset w16 ready after edge in reset", {63'b0, sr16}, 64'd0);
        #9 rst_n = 1'b1;
        step();
        check("w16 ready after release", {63'b0, sr16}, 64'd1);
        check("w64 ready after release", {63'b0, sr64}, 64'd1);

        // W=16 digest tid 1; request inputs scrambled during SEND
        load(16, pat, 1'b1, 2'd1, 1'b0);
        mode16 = 1'b0; tid16 = 2'd3; st16 = ~pat;
        wait_idle(16);
        check("t1 beats", cap16.size(), 64'd16);
        if (cap16.size() == 16) begin
            check("t1 beat0 tdata", cap16[0].data, 64'h0001);
            check("t1 beat1 tdata", cap16[1].data, 64'h0203);
            check("t1 beat15 tdata", cap16[15].data, 64'h0303);
            check("t1 beat15 tlast", {63'b0, cap16[15].last}, 64'd1);
            check("t1 beat14 tlast", {63'b0, cap16[14].last}, 64'd0);
            check("t1 beat15 tkeep", {56'b0, cap16[15].keep}, 64'h3);
            check("t1 tid", {62'b0, cap16[7].tid}, 64'd1);
        end
        ref16 = cap16;
        cap16.delete();

        // W=16 full state: 100 beats, state_ready low while streaming
        load(16, pat, 1'b0, 2'd2, 1'b0);
        hit = 1'b0;
        for (int k = 0; k < 400 && !hit; k++) begin
            @(negedge clk);
            #1;
            if (cap16.size() >= 100) hit = 1'b1;
            else if (tv16) check("t2 state_ready during packet", {63'b0, sr16}, 64'd0);
        end
        if (!hit) fail_now("t2 stream timeout");
        wait_idle(16);
        check("t2 state_ready after packet", {63'b0, sr16}, 64'd1);
        check("t2 beats", cap16.size(), 64'd100);
        if (cap16.size() == 100) begin
            check("t2 beat99 tdata", cap16[99].data, 64'h1818);
            check("t2 beat99 tkeep/tlast", {55'b0, cap16[99].keep, cap16[99].last}, {55'b0, 8'h03, 1'b1});
        end
        cap16.delete();

        // W=64 tid 0 (partial last beat) and tid 3
        load(64, pat, 1'b1, 2'd0, 1'b0);
        wait_idle(64);
        check("t3 tid0 beats", cap64.size(), 64'd4);
        if (cap64.size() == 4) begin
            check("t3 beat0 tdata", cap64[0].data, 64'h0706050403020100);
            check("t3 beat3 tdata", cap64[3].data, 64'h0000000003030303);
            check("t3 beat3 tkeep", {56'b0, cap64[3].keep}, 64'h0F);
            check("t3 beat2 tkeep", {56'b0, cap64[2].keep}, 64'hFF);
            check("t3 beat3 tlast", {63'b0, cap64[3].last}, 64'd1);
        end
        cap64.delete();
        load(64, pat, 1'b1, 2'd3, 1'b0);
        wait_idle(64);
        check("t3 tid3 beats", cap64.size(), 64'd8);
        if (cap64.size() == 8) begin
            for (int i = 0; i < 8; i++) check("t3 tid3 tkeep", {56'b0, cap64[i].keep}, 64'hFF);
            check("t3 beat7 tdata", cap64[7].data, 64'h0707070707070707);
            check("t3 beat7 tid/tlast", {61'b0, cap64[7].tid, cap64[7].last}, 64'h7);
        end
        cap64.delete();

        // Backpressure: stall 5 cycles on beat 3
        load(16, pat, 1'b1, 2'd1, 1'b0);
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            if (cap16.size() == 3) begin
                hit = 1'b1;
                trdy16 = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    #1;
                    check("t4 stall tvalid", {63'b0, tv16}, 64'd1);
                    check("t4 stall tdata", {48'b0, td16}, 64'h0607);
                    step();
                end
                trdy16 = 1'b1;
            end else step();
        end
        if (!hit) fail_now("t4 reach beat 3");
        wait_idle(16);
        check("t4 beats", cap16.size(), 64'd16);
        if (cap16.size() == 16 && ref16.size() == 16)
            for (int i = 0; i < 16; i++) check("t4 data vs no-stall", cap16[i].data, ref16[i].data);
        cap16.delete();

        // Back-to-back: tid 1 then tid 3 with state_valid held high
        load(16, pat, 1'b1, 2'd1, 1'b1);
        load(16, ~pat, 1'b1, 2'd3, 1'b0);
        wait_idle(16);
        check("t5 beats", cap16.size(), 64'd48);
        if (cap16.size() == 48) begin
            check("t5 no bubble span", 64'(cap16[47].cyc - cap16[0].cyc), 64'd47);
            check("t5 beat15 tid/tlast", {61'b0, cap16[15].tid, cap16[15].last}, 64'h3);
            check("t5 beat16 tid", {62'b0, cap16[16].tid}, 64'd3);
            check("t5 beat16 tdata", cap16[16].data, 64'hFFFE);
        end
        cap16.delete();

        // Reset in the middle of a full-state packet
        load(16, pat, 1'b0, 2'd0, 1'b0);
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            if (cap16.size() == 7) hit = 1'b1;
            else step();
        end
        if (!hit) fail_now("t6 reach beat 7");
        rst_n = 1'b0;
        #1;
        check("t6 tvalid drops at reset", {63'b0, tv16}, 64'd0);
        check("t6 tlast/ready in reset", {62'b0, tl16, sr16}, 64'd0);
        check("t6 tdata in reset", {48'b0, td16}, 64'd0);
        q16.delete();
        cap16.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        check("t6 ready after release", {63'b0, sr16}, 64'd1);
        load(16, pat, 1'b1, 2'd1, 1'b0);
        wait_idle(16);
        check("t6 beats after reset", cap16.size(), 64'd16);
        if (cap16.size() == 16) begin
            check("t6 beat0 tdata", cap16[0].data, 64'h0001);
            check("t6 beat0 tid", {62'b0, cap16[0].tid}, 64'd1);
        end

        check("model queue w16 drained", q16.size(), 64'd0);
        check("model queue w64 drained", q64.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
